// File: rtl/mem_access_ctrl.sv
// Avalon-MM master sequencer sharing one bus port between instruction fetch and data load/store.
// Optional wait-request timeout fault is enabled by defining MEMCTRL_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | read instruction at pc_in (or halt if pc_in == HALT_ADDR)
// S_EXEC  | one idle bus cycle; decide on load/store, latch operands
// S_DATA  | perform latched load or store
// S_HALT  | halted, waits for reset
// S_FAULT | bus timeout, waits for reset
module mem_access_ctrl #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
`ifdef MEMCTRL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_byteen,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        fetch,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        stall,
    output logic        active,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic [31:0] rdata_q;
    logic        dm_done_q;

    logic in_fetch;
    logic in_data;
    logic halt_pc;

    assign in_fetch = (state_q == S_FETCH);
    assign in_data  = (state_q == S_DATA);
    assign halt_pc  = (pc_in == HALT_ADDR);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            wr_q          <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            rdata_q       <= '0;
            dm_done_q     <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            dm_done_q     <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            // waits are consecutive within one access, so any non-wait cycle restarts the count
            wait_cnt_q    <= '0;
`endif
            case (state_q)
                S_FETCH: begin
                    if (halt_pc) begin
                        state_q <= S_HALT;
                    end else if (!avm_waitrequest) begin
                        instr_q       <= avm_readdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_EXEC;
                    end else begin
`ifdef MEMCTRL_TIMEOUT_EN
                        if (wait_cnt_q == TC_LAST) state_q <= S_FAULT;
                        else wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
                    end
                end
                S_EXEC: begin
                    if (dm_write || dm_read) begin
                        addr_q  <= dm_addr;
                        wdata_q <= dm_wdata;
                        be_q    <= dm_byteen;
                        wr_q    <= dm_write;
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DATA: begin
                    if (!avm_waitrequest) begin
                        if (!wr_q) rdata_q <= avm_readdata;
                        dm_done_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else begin
`ifdef MEMCTRL_TIMEOUT_EN
                        if (wait_cnt_q == TC_LAST) state_q <= S_FAULT;
                        else wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
                    end
                end
                S_HALT:  state_q <= S_HALT;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Bus outputs are held at zero while reset is asserted so an abandoned access is not re-issued.
    assign avm_read       = ~reset & ((in_fetch & ~halt_pc) | (in_data & ~wr_q));
    assign avm_write      = ~reset & in_data & wr_q;
    assign avm_address    = reset ? 32'h0 : (in_fetch ? pc_in : addr_q);
    assign avm_byteenable = reset ? 4'h0 : (in_fetch ? 4'hF : be_q);
    assign avm_writedata  = reset ? 32'h0 : wdata_q;

    assign fetch       = in_fetch;
    assign stall       = in_fetch | in_data;
    assign active      = (state_q != S_HALT) && (state_q != S_FAULT);
    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign dm_rdata    = rdata_q;
    assign dm_done     = dm_done_q;

`ifdef MEMCTRL_TIMEOUT_EN
    assign fault = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; covers the timeout fault when
// MEMCTRL_TIMEOUT_EN is defined, otherwise checks that waits never fault.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        fetch;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall;
    logic        active;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .HALT_ADDR(32'h0000_0000)
`ifdef MEMCTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_in(pc_in),
        .dm_read(dm_read),
        .dm_write(dm_write),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .fetch(fetch),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .dm_rdata(dm_rdata),
        .dm_done(dm_done),
        .stall(stall),
        .active(active),
        .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        pc_in           = 32'h4;
        dm_read         = 1'b0;
        dm_write        = 1'b0;
        dm_addr         = '0;
        dm_wdata        = '0;
        dm_byteen       = '0;
        avm_readdata    = 32'h2402000A;
        avm_waitrequest = 1'b0;

        tick();
        tick();
        chk("rst_read",    32'(avm_read), 0);
        chk("rst_write",   32'(avm_write), 0);
        chk("rst_addr",    avm_address, 0);
        chk("rst_wdata",   avm_writedata, 0);
        chk("rst_be",      32'(avm_byteenable), 0);
        chk("rst_instr",   instr_out, 0);
        chk("rst_ivalid",  32'(instr_valid), 0);
        chk("rst_rdata",   dm_rdata, 0);
        chk("rst_done",    32'(dm_done), 0);
        chk("rst_fetch",   32'(fetch), 1);
        chk("rst_stall",   32'(stall), 1);
        chk("rst_active",  32'(active), 1);
        chk("rst_fault",   32'(fault), 0);

        // zero-wait fetch, no memory op
        reset = 1'b0;
        settle();
        chk("f0_read",  32'(avm_read), 1);
        chk("f0_addr",  avm_address, 32'h4);
        chk("f0_be",    32'(avm_byteenable), 32'hF);
        chk("f0_write", 32'(avm_write), 0);
        tick();
        chk("f1_ivalid", 32'(instr_valid), 1);
        chk("f1_instr",  instr_out, 32'h2402000A);
        chk("f1_read",   32'(avm_read), 0);
        chk("f1_fetch",  32'(fetch), 0);
        chk("f1_stall",  32'(stall), 0);
        tick();
        chk("f2_fetch",  32'(fetch), 1);
        chk("f2_ivalid", 32'(instr_valid), 0);

        // fetch with three wait cycles
        pc_in           = 32'h8;
        avm_readdata    = 32'h1111_2222;
        avm_waitrequest = 1'b1;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("fw_read",   32'(avm_read), 1);
            chk("fw_addr",   avm_address, 32'h8);
            chk("fw_ivalid", 32'(instr_valid), 0);
            chk("fw_stall",  32'(stall), 1);
            tick();
        end
        avm_waitrequest = 1'b0;
        settle();
        chk("fw_read_last", 32'(avm_read), 1);
        chk("fw_addr_last", avm_address, 32'h8);
        tick();
        chk("fw_ivalid_pulse", 32'(instr_valid), 1);
        chk("fw_instr",        instr_out, 32'h1111_2222);

        // store with simultaneous read request; write must win
        dm_write  = 1'b1;
        dm_read   = 1'b1;
        dm_addr   = 32'h100;
        dm_wdata  = 32'hDEADBEEF;
        dm_byteen = 4'b0011;
        tick();
        dm_write  = 1'b0;
        dm_read   = 1'b0;
        dm_addr   = 32'hFFF0;
        dm_wdata  = 32'h0BAD_0BAD;
        dm_byteen = 4'b1100;
        settle();
        chk("st_ivalid_gone", 32'(instr_valid), 0);
        chk("st_write",  32'(avm_write), 1);
        chk("st_read",   32'(avm_read), 0);
        chk("st_addr",   avm_address, 32'h100);
        chk("st_wdata",  avm_writedata, 32'hDEADBEEF);
        chk("st_be",     32'(avm_byteenable), 32'h3);
        chk("st_stall",  32'(stall), 1);
        chk("st_fetch",  32'(fetch), 0);
        tick();
        chk("st_done",   32'(dm_done), 1);
        chk("st_write_off", 32'(avm_write), 0);
        chk("st_fetch_back", 32'(fetch), 1);
        chk("st_rdata_kept", dm_rdata, 0);

        // load from 0x200 with two waits
        pc_in        = 32'hC;
        avm_readdata = 32'h0000_0001;
        tick();
        chk("ld_done_cleared", 32'(dm_done), 0);
        dm_read = 1'b1;
        dm_addr = 32'h200;
        tick();
        dm_read         = 1'b0;
        dm_addr         = 32'hFFF0;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'h1234_5678;
        settle();
        for (int i = 0; i < 2; i++) begin
            chk("ld_read",  32'(avm_read), 1);
            chk("ld_addr",  avm_address, 32'h200);
            chk("ld_write", 32'(avm_write), 0);
            tick();
            chk("ld_done_early", 32'(dm_done), 0);
        end
        avm_waitrequest = 1'b0;
        settle();
        chk("ld_read_last", 32'(avm_read), 1);
        tick();
        chk("ld_done",  32'(dm_done), 1);
        chk("ld_rdata", dm_rdata, 32'h1234_5678);
        chk("ld_fetch", 32'(fetch), 1);

        // reset during a waited load
        dm_read = 1'b1;
        dm_addr = 32'h300;
        tick();
        tick();
        dm_read         = 1'b0;
        avm_waitrequest = 1'b1;
        settle();
        chk("rm_read", 32'(avm_read), 1);
        chk("rm_addr", avm_address, 32'h300);
        tick();
        reset = 1'b1;
        tick();
        chk("rm_read_off",  32'(avm_read), 0);
        chk("rm_write_off", 32'(avm_write), 0);
        chk("rm_no_done",   32'(dm_done), 0);
        chk("rm_fetch",     32'(fetch), 1);
        avm_waitrequest = 1'b0;
        tick();
        chk("rm_no_done2",  32'(dm_done), 0);
        chk("rm_rdata_clr", dm_rdata, 0);

        // halt on pc_in == HALT_ADDR
        pc_in = 32'h0;
        reset = 1'b0;
        settle();
        chk("h_read",   32'(avm_read), 0);
        chk("h_write",  32'(avm_write), 0);
        chk("h_active_first", 32'(active), 1);
        tick();
        chk("h_active", 32'(active), 0);
        chk("h_fetch",  32'(fetch), 0);
        chk("h_stall",  32'(stall), 0);
        pc_in = 32'h4;
        tick();
        tick();
        chk("h_stay_active", 32'(active), 0);
        chk("h_stay_read",   32'(avm_read), 0);
        chk("h_fault",       32'(fault), 0);

        // waitrequest held high on a fetch
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        avm_waitrequest = 1'b1;
        settle();
`ifdef MEMCTRL_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("to_fault_early",  32'(fault), 0);
        chk("to_read_waiting", 32'(avm_read), 1);
        tick();
        chk("to_fault",  32'(fault), 1);
        chk("to_active", 32'(active), 0);
        chk("to_read",   32'(avm_read), 0);
        chk("to_write",  32'(avm_write), 0);
        chk("to_stall",  32'(stall), 0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nto_fault",  32'(fault), 0);
        chk("nto_active", 32'(active), 1);
        chk("nto_read",   32'(avm_read), 1);
        chk("nto_addr",   avm_address, 32'h4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer that owns the CPU's single Avalon memory-mapped master port and shares it between instruction fetch and data load/store. Drives the fetch strobe and instruction capture that feed the instruction register, stalls the datapath while `waitrequest` is high, and detects the halt condition (jump to `HALT_ADDR`). Sits between the CPU core (PC, decode, load/store unit) and the external memory bus.

## Interface
- `HALT_ADDR`, 32'h0000_0000, fetch address that halts the CPU
- `TIMEOUT_CYCLES`, 255, maximum consecutive `avm_waitrequest` cycles before fault (only with `MEMCTRL_TIMEOUT_EN`); range 1..65535

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `pc_in`  in  32  fetch address from PC logic, sampled in FETCH
- `dm_read`  in  1  load request, sampled in EXEC
- `dm_write`  in  1  store request, sampled in EXEC
- `dm_addr`  in  32  load/store address, sampled in EXEC
- `dm_wdata`  in  32  store data, sampled in EXEC
- `dm_byteen`  in  4  byte enables, sampled in EXEC
- `avm_address`  out  32  bus address
- `avm_read`  out  1  bus read strobe
- `avm_write`  out  1  bus write strobe
- `avm_writedata`  out  32  bus write data
- `avm_byteenable`  out  4  bus byte enables
- `avm_readdata`  in  32  bus read data
- `avm_waitrequest`  in  1  bus stall
- `fetch`  out  1  high while in FETCH; drives instruction register fetch input
- `instr_out`  out  32  last fetched instruction
- `instr_valid`  out  1  one-cycle pulse: `instr_out` updated
- `dm_rdata`  out  32  last load data
- `dm_done`  out  1  one-cycle pulse: load/store completed
- `stall`  out  1  high whenever bus access pending (FETCH or DATA)
- `active`  out  1  high until halt or fault
- `fault`  out  1  sticky bus-timeout flag

## Operation
- States: FETCH, EXEC, DATA, HALT, FAULT. Reset state FETCH.
- FETCH: if `pc_in == HALT_ADDR` → HALT, no bus access. Else `avm_read=1`, `avm_address=pc_in`, `avm_byteenable=4'hF`; on cycle with `avm_waitrequest=0`: register `avm_readdata` into `instr_out`, pulse `instr_valid` next cycle, → EXEC.
- EXEC: one cycle, no bus activity. `dm_write` → DATA (write); else `dm_read` → DATA (read); else → FETCH. Both high: write wins, read dropped. Address/data/byteen latched into internal registers on leaving EXEC; bus outputs driven from latches.
- DATA: read: `avm_read=1`, completion captures `avm_readdata` into `dm_rdata`. Write: `avm_write=1`, `avm_writedata`/`avm_byteenable` from latches. Completion (`waitrequest=0`) → FETCH, pulse `dm_done` next cycle.
- HALT: all strobes low, `active=0`, stays until reset.
- FAULT: all strobes low, `active=0`, `fault=1`, stays until reset.
- `avm_read` and `avm_write` never high together. Bus outputs constant while `waitrequest` high.
- Reset values: all strobes 0, `avm_address/writedata=0`, `avm_byteenable=0`, `instr_out=0`, `dm_rdata=0`, `instr_valid=0`, `dm_done=0`, `fetch=1`, `stall=1`, `active=1`, `fault=0`.
- Reset mid-access: transaction abandoned; state FETCH next cycle regardless of `waitrequest`; no `instr_valid`/`dm_done` pulse.

## Timing
- Strobes, `fetch`, `stall` are Moore outputs decoded from the state register.
- Zero-wait instruction with no memory op: FETCH, EXEC = 2 cycles; `instr_valid` high in the EXEC cycle.
- Each wait cycle extends FETCH/DATA by one; access with n wait cycles takes n+1 cycles.
- Load/store, zero-wait: FETCH, EXEC, DATA = 3 cycles; `dm_done` high in the following FETCH cycle.
- Halt detected in the first FETCH cycle; `active` low from the next cycle.

## Configuration
- `MEMCTRL_TIMEOUT_EN` defined: 16-bit counter clears on entering FETCH/DATA, increments each cycle `avm_waitrequest=1` there; reaching `TIMEOUT_CYCLES` → FAULT on next edge, strobes dropped.
- Undefined: no counter, waits indefinitely, FAULT unreachable, `fault` tied 0.

## Test plan
- Reset, `pc_in=0x4`, readdata `0x2402000A`, no wait → `avm_read` cycle 0, `instr_valid` cycle 1, `instr_out=0x2402000A`, back in FETCH cycle 2.
- Fetch with 3 wait cycles → `avm_read` and `avm_address` stable 4 cycles, single `instr_valid` pulse.
- EXEC with `dm_write=1`, `dm_addr=0x100`, `dm_wdata=0xDEADBEEF`, `dm_byteen=4'b0011` → one write cycle with those values, `dm_done` pulse; simultaneous `dm_read=1` ignored.
- Load from 0x200 returning `0x12345678` after 2 waits → `dm_rdata=0x12345678`, `dm_done` pulse, next FETCH.
- `pc_in=0` in FETCH → no bus strobes, `active=0` next cycle, remains halted; reset asserted during a waited DATA read → strobes low next cycle, no `dm_done`.
- With `MEMCTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, waitrequest held high → `fault=1`, `active=0` after 4 wait cycles, strobes low.
